// File: rtl/logistic_map_engine.sv
// logistic_map_engine: multi-channel fixed-point logistic-map iterator, x' = mu*x*(1-x),
// round-robin over one shared 2-stage multiply pipeline with a valid/ready snapshot stream.
module logistic_map_engine #(
    parameter int WIDTH    = 17,
    parameter int MU_W     = 18,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter bit STREAM   = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      start,
    input  logic [CHANNELS*WIDTH-1:0] x0,
    input  logic [CHANNELS*MU_W-1:0]  mu,
    input  logic [CNT_W-1:0]          iterations,
    output logic                      busy,
    output logic                      done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          out_iter,
    output logic [CHANNELS*WIDTH-1:0] x_out
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW   = $clog2(CHANNELS + 2);
    localparam int TW   = 2 * WIDTH;
    localparam int PW   = MU_W + WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, EMIT, FIN} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] iter_cap, iter_next;
    logic [WIDTH-1:0] xs [CHANNELS];
    logic [MU_W-1:0]  mus [CHANNELS];
    logic [CH_W-1:0]  ch_issue, ch1, ch2;
    logic             v1, v2, last, issue;
    logic [WIDTH-1:0] t_n, t_r, y_n, y_r;
    logic [TW-1:0]    p1;
    logic [PW-1:0]    p2;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_out
        assign x_out[k*WIDTH +: WIDTH] = xs[k];
    end

    always_comb begin
        last      = cnt == CW'(CHANNELS + 1);
        issue     = state == RUN && cnt < CW'(CHANNELS);
        ch_issue  = CH_W'(cnt);
        iter_next = &out_iter ? out_iter : out_iter + CNT_W'(1);
        p1        = TW'(xs[ch_issue]) * TW'({1'b1, {WIDTH{1'b0}}} - {1'b0, xs[ch_issue]});
        t_n       = WIDTH'(p1 >> WIDTH);
        p2        = (PW'(mus[ch1]) * PW'(t_r)) >> (MU_W - 2);
        y_n       = |p2[PW-1:WIDTH] ? '1 : p2[WIDTH-1:0];
        state_n   = state;
        case (state)
            IDLE:    if (start) state_n = (iterations == '0) ? FIN : RUN;
            RUN:     if (last && (STREAM || iter_next == iter_cap)) state_n = EMIT;
            EMIT:    if (out_ready) state_n = (out_iter == iter_cap) ? FIN : RUN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else state <= state_n;
    end

    // Channel k is issued in RUN cycle k and written back at the end of cycle k+2.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_iter  <= '0;
            iter_cap  <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            ch1       <= '0;
            ch2       <= '0;
            t_r       <= '0;
            y_r       <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                xs[k]  <= '0;
                mus[k] <= '0;
            end
        end else begin
            cnt  <= (state == RUN && !last) ? cnt + CW'(1) : '0;
            done <= state == FIN;
            v1   <= issue;
            ch1  <= ch_issue;
            t_r  <= t_n;
            v2   <= v1;
            ch2  <= ch1;
            y_r  <= y_n;
            if (v2) xs[ch2] <= y_r;
            if (state == IDLE && start) begin
                busy     <= 1'b1;
                out_iter <= '0;
                iter_cap <= iterations;
                for (int k = 0; k < CHANNELS; k++) begin
                    xs[k]  <= x0[k*WIDTH +: WIDTH];
                    mus[k] <= mu[k*MU_W +: MU_W];
                end
            end
            if (state == RUN && last) out_iter <= iter_next;
            if (state == RUN && state_n == EMIT) out_valid <= 1'b1;
            if (state == EMIT && out_ready) out_valid <= 1'b0;
            if (state == FIN) busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_logistic_map_engine.sv
// tb_logistic_map_engine: directed bench for logistic_map_engine with a snapshot scoreboard;
// one streaming instance and one final-snapshot-only instance.
module tb_logistic_map_engine;
    localparam int W = 17, M = 18, C = 4, N = 16;
    typedef struct { logic [N-1:0] it; logic [C*W-1:0] x; } snap_t;

    logic CLK = 0, RST_N = 0, start = 0, start0 = 0, out_ready = 1;
    logic [C*W-1:0] x0 = '0;
    logic [C*M-1:0] mu = '0;
    logic [N-1:0] iterations = '0;
    logic busy, done, out_valid, busy0, done0, out_valid0;
    logic [N-1:0] out_iter, out_iter0;
    logic [C*W-1:0] x_out, x_out0;
    int n_checks = 0, n_fail = 0, cyc = 0, start_cyc = 0, done_cnt = 0, acc_cnt = 0;
    snap_t q[$];

    logistic_map_engine #(.WIDTH(W), .MU_W(M), .CHANNELS(C), .CNT_W(N), .STREAM(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .x0(x0), .mu(mu), .iterations(iterations),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_iter(out_iter), .x_out(x_out));

    logistic_map_engine #(.WIDTH(W), .MU_W(M), .CHANNELS(C), .CNT_W(N), .STREAM(1'b0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .start(start0), .x0(x0), .mu(mu), .iterations(iterations),
        .busy(busy0), .done(done0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_iter(out_iter0), .x_out(x_out0));

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (done || done0) done_cnt <= done_cnt + 1;
        if ((out_valid || out_valid0) && out_ready) acc_cnt <= acc_cnt + 1;
    end

    function automatic logic [W-1:0] step(input logic [W-1:0] x, input logic [M-1:0] m);
        longint t, y;
        t = (longint'(x) * (131072 - longint'(x))) / 131072;
        y = (longint'(m) * t) / 65536;
        return (y > 131071) ? 17'd131071 : W'(y);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input bit sel, input logic [C*W-1:0] xv, input logic [C*M-1:0] mv, input logic [N-1:0] it);
        logic [C*W-1:0] cur;
        snap_t s;
        x0 = xv;
        mu = mv;
        iterations = it;
        cur = xv;
        for (int i = 1; i <= int'(it); i++) begin
            for (int k = 0; k < C; k++) cur[k*W +: W] = step(cur[k*W +: W], mv[k*M +: M]);
            if (!sel || i == int'(it)) begin
                s.it = N'(i);
                s.x = cur;
                q.push_back(s);
            end
        end
        if (sel) start0 = 1;
        else start = 1;
        tick(1);
        start = 0;
        start0 = 0;
        start_cyc = cyc;
        check("start_busy", sel ? busy0 : busy, 1);
    endtask

    task automatic collect(input bit sel, input int stall_at);
        snap_t s;
        int w;
        for (int n = 0; q.size() > 0; n++) begin
            if (n == stall_at) out_ready = 0;
            w = 0;
            while (!(sel ? out_valid0 : out_valid) && w < 300) begin
                tick(1);
                w++;
            end
            s = q.pop_front();
            check("snap_valid", sel ? out_valid0 : out_valid, 1);
            check("snap_iter", sel ? out_iter0 : out_iter, s.it);
            check("snap_x", sel ? x_out0 : x_out, s.x);
            if (n == stall_at) begin
                for (int i = 0; i < 10; i++) begin
                    tick(1);
                    check("stall_valid", sel ? out_valid0 : out_valid, 1);
                    check("stall_iter", sel ? out_iter0 : out_iter, s.it);
                    check("stall_x", sel ? x_out0 : x_out, s.x);
                end
                out_ready = 1;
            end
            tick(1);
        end
    endtask

    task automatic wait_done(input bit sel, input int exp_lat);
        int w = 0;
        while (!(sel ? done0 : done) && w < 400) begin
            tick(1);
            w++;
        end
        check("done_seen", sel ? done0 : done, 1);
        check("latency", cyc - start_cyc, exp_lat);
        check("busy_at_done", sel ? busy0 : busy, 0);
        tick(1);
        check("done_pulse", sel ? done0 : done, 0);
    endtask

    initial begin
        logic [C*W-1:0] xa, xb;
        logic [C*M-1:0] mb;
        int d0, a0;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_iter", out_iter, 0);
        check("rst_x", x_out, 0);
        check("rst_x_s0", x_out0, 0);
        RST_N = 1;
        tick(1);

        // mu=3.0, x0=0.5 on ch0 with three other orbits alongside
        d0 = done_cnt;
        a0 = acc_cnt;
        launch(0, {17'd0, 17'd13107, 17'd32768, 17'd65536}, {18'h10000, 18'h3E666, 18'h20000, 18'h30000}, 2);
        collect(0, -1);
        wait_done(0, 15);
        check("t2_ch0", x_out[W-1:0], 73728);
        check("t2_iter_hold", out_iter, 2);
        check("t2_done_cnt", done_cnt - d0, 1);
        check("t2_accepts", acc_cnt - a0, 2);

        launch(0, {4{17'd65536}}, {18'h20000, 18'h30000, 18'h3FFFF, 18'h00000}, 1);
        collect(0, -1);
        wait_done(0, 8);
        check("t3_x", x_out, {17'd65536, 17'd98304, 17'd131071, 17'd0});

        launch(0, '0, {18'h3FFFF, 18'h30000, 18'h20000, 18'h10000}, 4);
        collect(0, -1);
        wait_done(0, 29);
        check("t4_fixed_zero", x_out, 0);

        a0 = acc_cnt;
        xa = {17'd1234, 17'd99999, 17'd65536, 17'd7};
        launch(0, xa, {4{18'h30000}}, 0);
        wait_done(0, 1);
        check("t4_zero_x", x_out, xa);
        check("t4_zero_iter", out_iter, 0);
        check("t4_zero_accepts", acc_cnt - a0, 0);

        xb = {17'd100000, 17'd50000, 17'd20000, 17'd70000};
        mb = {18'h3C000, 18'h2E000, 18'h38000, 18'h3A000};
        launch(0, xb, mb, 3);
        collect(0, 1);
        wait_done(0, 32);

        launch(0, xa, mb, 2);
        tick(3);
        x0 = {4{17'd4242}};
        mu = '0;
        iterations = 9;
        start = 1;
        tick(1);
        start = 0;
        check("t6_still_busy", busy, 1);
        collect(0, -1);
        wait_done(0, 15);

        a0 = acc_cnt;
        launch(1, xb, mb, 3);
        collect(1, -1);
        wait_done(1, 20);
        check("t6_final_only", acc_cnt - a0, 1);
        check("t6_iter_final", out_iter0, 3);

        // abort a run with a 2-cycle reset; no done may follow
        d0 = done_cnt;
        launch(0, xb, mb, 3);
        tick(8);
        RST_N = 0;
        tick(2);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_valid", out_valid, 0);
        check("abort_iter", out_iter, 0);
        check("abort_x", x_out, 0);
        RST_N = 1;
        q.delete();
        tick(40);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", busy, 0);
        check("abort_no_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
